// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite constants, tester state encoding and pattern helpers
// for the memory tester. The pattern generator uses the LFSR step helper
// when AHB_MEM_TESTER_LFSR_EN is defined.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Tester state encoding
  typedef logic [2:0] tester_state_t;
  localparam tester_state_t ST_IDLE    = 3'd0;
  localparam tester_state_t ST_WR_ADDR = 3'd1;
  localparam tester_state_t ST_WR_DATA = 3'd2;
  localparam tester_state_t ST_RD_ADDR = 3'd3;
  localparam tester_state_t ST_RD_DATA = 3'd4;
  localparam tester_state_t ST_DONE    = 3'd5;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Right-shifting Galois LFSR: the toggle mask is applied when a one falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/ahb_lite_tester_pattern.sv
// Data pattern generator for the memory tester.
// AHB_MEM_TESTER_LFSR_EN defined : 32-bit Galois LFSR, reloaded by load_i,
//                                  advanced once per step_i.
// AHB_MEM_TESTER_LFSR_EN undefined: word address XOR seed.
module ahb_lite_tester_pattern (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] seed_i,
  input  logic [31:0] addr_i,
  output logic [31:0] data_o
);
  import ahb_lite_pkg::*;

`ifdef AHB_MEM_TESTER_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] unused_addr;

  assign unused_addr = addr_i;

  // Load has priority so a pass boundary always restarts from the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)      lfsr_d = seed_i;
    else if (step_i) lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR state register
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

  assign data_o = lfsr_q;
`else
  logic [31:0] seed_q;
  logic        unused_step;

  assign unused_step = step_i;

  // Seed captured at the start of each pass; the address supplies the variation.
  always_ff @(posedge clk) begin
    if (rst)         seed_q <= '0;
    else if (load_i) seed_q <= seed_i;
  end

  assign data_o = addr_i ^ seed_q;
`endif

endmodule

// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite master that writes a deterministic pattern over WORD_COUNT words
// starting at ADDR_BASE, reads it back and reports mismatches / bus errors.
// Transfers are non-pipelined: one address phase, then one data phase.
// Pattern source selected by AHB_MEM_TESTER_LFSR_EN (see pattern sub-module).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset, waiting for start
// WR_ADDR  | write address phase, NONSEQ driven until HREADY
// WR_DATA  | write data phase, HWDATA held until HREADY
// RD_ADDR  | read address phase, NONSEQ driven until HREADY
// RD_DATA  | read data phase, HRDATA compared on HREADY
// DONE     | results valid, waiting for the next start
module ahb_lite_mem_tester #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          WORD_COUNT  = 1024,
  parameter logic [31:0] DATA_SEED   = 32'hA5A5_0000,
  parameter int          ERRCNT_BITS = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   bus_err,
  output logic [ERRCNT_BITS-1:0] err_count,
  output logic [31:0]            fail_addr,
  output logic [31:0]            fail_data,
  output logic [31:0]            HADDR,
  output logic [2:0]             HBURST,
  output logic [2:0]             HSIZE,
  output logic [1:0]             HTRANS,
  output logic                   HWRITE,
  output logic [31:0]            HWDATA,
  input  logic [31:0]            HRDATA,
  input  logic                   HREADY,
  input  logic                   HRESP
);
  import ahb_lite_pkg::*;

  // Words remaining after the current one; reaching zero marks the last word.
  localparam logic [23:0] LAST_IDX = 24'(WORD_COUNT - 1);

  tester_state_t          state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [23:0]            remain_q, remain_d;
  logic [31:0]            hwdata_q, hwdata_d;
  logic                   bus_err_q, bus_err_d;
  logic [ERRCNT_BITS-1:0] err_count_q, err_count_d;
  logic [31:0]            fail_addr_q, fail_addr_d;
  logic [31:0]            fail_data_q, fail_data_d;

  logic        pat_load;
  logic        pat_step;
  logic [31:0] pat_data;

  ahb_lite_tester_pattern u_pattern (
    .clk    (HCLK),
    .rst    (HRESET),
    .load_i (pat_load),
    .step_i (pat_step),
    .seed_i (DATA_SEED),
    .addr_i (addr_q),
    .data_o (pat_data)
  );

  // Next-state, address walk, data-phase completion and result capture
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    hwdata_d    = hwdata_q;
    bus_err_d   = bus_err_q;
    err_count_d = err_count_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    pat_load    = 1'b0;
    pat_step    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_WR_ADDR;
          addr_d      = ADDR_BASE;
          remain_d    = LAST_IDX;
          bus_err_d   = 1'b0;
          err_count_d = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          pat_load    = 1'b1;
        end
      end

      ST_WR_ADDR: begin
        if (HREADY) begin
          state_d  = ST_WR_DATA;
          hwdata_d = pat_data;
        end
      end

      ST_WR_DATA: begin
        if (HREADY) begin
          if (HRESP == HRESP_ERROR) begin
            bus_err_d = 1'b1;
            state_d   = ST_DONE;
          end else if (remain_q == '0) begin
            // End of write pass: restart the walk and the pattern for read-back.
            state_d  = ST_RD_ADDR;
            addr_d   = ADDR_BASE;
            remain_d = LAST_IDX;
            pat_load = 1'b1;
          end else begin
            state_d  = ST_WR_ADDR;
            addr_d   = addr_q + 32'd4;
            remain_d = remain_q - 24'd1;
            pat_step = 1'b1;
          end
        end
      end

      ST_RD_ADDR: begin
        if (HREADY) state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        if (HREADY) begin
          if (HRESP == HRESP_ERROR) begin
            bus_err_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            if (HRDATA != pat_data) begin
              if (err_count_q != {ERRCNT_BITS{1'b1}}) err_count_d = err_count_q + 1'b1;
              // A zero count can only mean no earlier mismatch, since it saturates.
              if (err_count_q == '0) begin
                fail_addr_d = addr_q;
                fail_data_d = HRDATA;
              end
            end
            pat_step = 1'b1;
            if (remain_q == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d  = ST_RD_ADDR;
              addr_d   = addr_q + 32'd4;
              remain_d = remain_q - 24'd1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      hwdata_q    <= '0;
      bus_err_q   <= 1'b0;
      err_count_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      hwdata_q    <= hwdata_d;
      bus_err_q   <= bus_err_d;
      err_count_q <= err_count_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign HADDR  = addr_q;
  assign HBURST = HBURST_SINGLE;
  assign HSIZE  = HSIZE_WORD;
  assign HTRANS = (state_q == ST_WR_ADDR || state_q == ST_RD_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE = (state_q == ST_WR_ADDR || state_q == ST_WR_DATA);
  assign HWDATA = hwdata_q;

  assign busy      = (state_q == ST_WR_ADDR) || (state_q == ST_WR_DATA) ||
                     (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
  assign done      = (state_q == ST_DONE);
  assign pass      = done && (err_count_q == '0) && !bus_err_q;
  assign bus_err   = bus_err_q;
  assign err_count = err_count_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_ahb_lite_mem_tester.sv
// Self-checking bench for ahb_lite_mem_tester with a reactive RAM slave
// (configurable wait states, read corruption and two-cycle ERROR response).
module tb_ahb_lite_mem_tester;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        pass;
    logic        bus_err;
    logic [15:0] err;
    logic [31:0] faddr;
    logic [31:0] fdata;
    int          busy;
    int          reads;
  } st_t;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, bus_err;
  logic [15:0] err_count;
  logic [31:0] fail_addr, fail_data;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_mem_tester #(
    .ADDR_BASE   (BASE),
    .WORD_COUNT  (4),
    .DATA_SEED   (SEED),
    .ERRCNT_BITS (16)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .bus_err   (bus_err),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .HADDR     (HADDR),
    .HBURST    (HBURST),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- RAM slave ----------------
  int          waits = 0;
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;
  int          err_at_wr = -1;
  int          wr_seen = 0;
  logic        ph_valid = 1'b0, ph_write = 1'b0, ph_err = 1'b0, err_2nd = 1'b0;
  logic [31:0] ph_addr = 32'h0;
  int          cnt = 0;
  logic [31:0] mem [0:63];
  logic        active;

  assign active = ph_valid || (HTRANS == 2'b10);
  assign HREADY = (ph_valid && ph_err) ? err_2nd : (!active || cnt >= waits);
  assign HRESP  = ph_valid && ph_err;
  assign HRDATA = (ph_valid && !ph_write) ?
                  (mem[ph_addr[7:2]] ^ ((corrupt_en && ph_addr == corrupt_addr) ? 32'h1 : 32'h0)) : 32'h0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      ph_valid <= 1'b0;
      ph_err   <= 1'b0;
      err_2nd  <= 1'b0;
      cnt      <= 0;
    end else begin
      err_2nd <= (ph_valid && ph_err && !err_2nd);
      if (active && !HREADY) cnt <= cnt + 1;
      else                   cnt <= 0;
      if (HREADY) begin
        if (ph_valid && ph_write && !ph_err) mem[ph_addr[7:2]] <= HWDATA;
        ph_valid <= (HTRANS == 2'b10);
        ph_addr  <= HADDR;
        ph_write <= HWRITE;
        ph_err   <= (HTRANS == 2'b10) && HWRITE && (wr_seen == err_at_wr);
        if (HTRANS == 2'b10 && HWRITE) wr_seen <= wr_seen + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  wr_t         wr_exp [$];
  st_t         st_exp [$];
  int          busy_cnt = 0;
  int          rd_cnt = 0;
  logic        stall_prev = 1'b0;
  logic        held_wdata = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic [1:0]  h_trans;

  always @(negedge HCLK) begin
    wr_t w;
    if (busy) busy_cnt++;
    if (!HRESET && ph_valid && HREADY && !HRESP) begin
      if (ph_write) begin
        if (wr_exp.size() == 0) chk("wr_unexpected", 32'(wr_exp.size()), 32'd1);
        else begin
          w = wr_exp.pop_front();
          chk("wr_addr", ph_addr, w.addr);
          chk("wr_data", HWDATA, w.data);
        end
      end else begin
        rd_cnt++;
      end
    end
    if (stall_prev && !HRESET) begin
      chk("hold_haddr", HADDR, h_addr);
      chk("hold_htrans", 32'(HTRANS), 32'(h_trans));
      if (held_wdata) chk("hold_hwdata", HWDATA, h_wdata);
    end
    stall_prev = !HREADY && !HRESET && (HTRANS == 2'b10 || ph_valid);
    held_wdata = ph_valid && ph_write;
    h_addr     = HADDR;
    h_trans    = HTRANS;
    h_wdata    = HWDATA;
  end

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) begin
      wr_t w;
      w.addr = BASE + 32'(4 * i);
      w.data = w.addr ^ SEED;
      wr_exp.push_back(w);
    end
  endtask

  task automatic pulse_start();
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
  endtask

  task automatic run_and_check(input logic mid_start, input st_t e, input int nwr);
    int  b0, r0;
    bit  seen;
    st_t got;
    push_writes(nwr);
    st_exp.push_back(e);
    @(negedge HCLK);
    b0 = busy_cnt;
    r0 = rd_cnt;
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_clr_done", 32'(done), 32'd0);
    chk("start_clr_err", 32'(err_count), 32'd0);
    chk("start_clr_faddr", fail_addr, 32'd0);
    if (mid_start) begin
      repeat (4) @(negedge HCLK);
      start = 1'b1;
      @(negedge HCLK);
      start = 1'b0;
      chk("mid_start_busy", 32'(busy), 32'd1);
    end
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge HCLK);
    end
    chk("done_timeout", 32'(seen), 32'd1);
    got = st_exp.pop_front();
    chk("pass", 32'(pass), 32'(got.pass));
    chk("bus_err", 32'(bus_err), 32'(got.bus_err));
    chk("err_count", 32'(err_count), 32'(got.err));
    chk("fail_addr", fail_addr, got.faddr);
    chk("fail_data", fail_data, got.fdata);
    chk("busy_after_done", 32'(busy), 32'd0);
    if (got.busy >= 0) chk("busy_cycles", 32'(busy_cnt - b0), 32'(got.busy));
    chk("reads", 32'(rd_cnt - r0), 32'(got.reads));
    chk("writes_left", 32'(wr_exp.size()), 32'd0);
    wr_exp.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("hburst", 32'(HBURST), 32'd0);
    chk("hsize", 32'(HSIZE), 32'd2);

    // zero-wait slave
    waits = 0;
    run_and_check(1'b0, '{1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 16, 4}, 4);

    // three wait states on every phase
    waits = 3;
    run_and_check(1'b0, '{1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 64, 4}, 4);
    waits = 0;

    // corrupted read at 0x108
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h108;
    run_and_check(1'b0, '{1'b0, 1'b0, 16'd1, 32'h108, 32'hA5A5_0109, 16, 4}, 4);
    corrupt_en = 1'b0;

    // restart from DONE clears results; a start while busy is ignored
    run_and_check(1'b1, '{1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 16, 4}, 4);

    // ERROR response on the second write of the run
    err_at_wr = wr_seen + 1;
    run_and_check(1'b0, '{1'b0, 1'b1, 16'd0, 32'd0, 32'd0, -1, 0}, 1);
    err_at_wr = -1;

    // reset during the second write's data phase
    push_writes(4);
    pulse_start();
    repeat (3) @(negedge HCLK);
    chk("pre_rst_state", 32'(HWRITE && busy && HTRANS == 2'b00), 32'd1);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("midrst_htrans", 32'(HTRANS), 32'd0);
    chk("midrst_haddr", HADDR, 32'd0);
    chk("midrst_hwrite", 32'(HWRITE), 32'd0);
    chk("midrst_hwdata", HWDATA, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    HRESET = 1'b0;
    wr_exp.delete();
    @(negedge HCLK);
    run_and_check(1'b0, '{1'b1, 1'b0, 16'd0, 32'd0, 32'd0, 16, 4}, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
